// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with sticky error flags feeding a first-word-fall-through FIFO
//
// Ports:
//   m_clock    : single clock, rising edge
//   p_reset    : synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   port_read  : pop the FIFO head (ignored when empty)
//   err_clr    : clear overrun/parity_err/frame_err (a same-cycle set wins)
//   data       : FIFO head, zero-extended above DATA_BITS, 0 when empty
//   rxready    : FIFO non-empty
//   done       : one-cycle pulse when a good character enters the FIFO
//   count      : FIFO occupancy
//   overrun    : sticky, good character dropped on a full FIFO
//   parity_err : sticky parity error
//   frame_err  : sticky framing error
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic          m_clock,
    input  logic          p_reset,
    input  logic          rxd,
    input  logic          port_read,
    input  logic          err_clr,
    output logic [7:0]    data,
    output logic          rxready,
    output logic          done,
    output logic [AW:0]   count,
    output logic          overrun,
    output logic          parity_err,
    output logic          frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAITHI} state_t;

    localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL_BIT  = 16'(CLKS_PER_BIT);
    localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic        ODD_PAR   = (PARITY == 2);

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bad_q, par_bad_d, frm_bad_q, frm_bad_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          overrun_q, overrun_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          tick, char_end, bad_frm, good, pop, push, drop, full;

    // Counter expires when it reaches 1, so a HALF_BIT load lands the first
    // sample near mid start-bit and FULL_BIT reloads space samples one bit apart.
    assign tick = (cnt_q <= 16'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        char_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (prev_q && !sync2_q) begin
                    state_d = S_START;
                    cnt_d   = HALF_BIT;
                end
            end
            S_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (sync2_q) begin
                    state_d = S_IDLE;   // line went back high: glitch
                end else begin
                    state_d   = S_DATA;
                    cnt_d     = FULL_BIT;
                    bit_d     = 3'd0;
                    shift_d   = 8'd0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d          = FULL_BIT;
                    shift_d[bit_q] = sync2_q;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d     = FULL_BIT;
                    par_bad_d = (^shift_q) ^ sync2_q ^ ODD_PAR;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    cnt_d = FULL_BIT;
                    if (!sync2_q) begin
                        frm_bad_d = 1'b1;
                    end
                    if (bit_q == LAST_STOP) begin
                        char_end = 1'b1;
                        state_d  = (frm_bad_q || !sync2_q) ? S_WAITHI : S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_WAITHI: begin
                if (sync2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The last stop sample is folded in directly so the push happens in
    // the same cycle that sample is taken.
    assign bad_frm = frm_bad_q || !sync2_q;
    assign good    = char_end && !par_bad_q && !bad_frm;
    assign full    = count[AW];
    assign pop     = port_read && rxready;
    assign push    = good && (!full || pop);
    assign drop    = good && full && !pop;

    always_comb begin
        sync1_d   = rxd;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        wr_ptr_d  = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
        overrun_d = drop || (overrun_q && !err_clr);
        perr_d    = (char_end && par_bad_q) || (perr_q && !err_clr);
        ferr_d    = (char_end && bad_frm) || (ferr_q && !err_clr);
    end

    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            frm_bad_q <= frm_bad_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge m_clock) begin
        if (push && !p_reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    assign count      = wr_ptr_q - rd_ptr_q;
    assign rxready    = (count != '0);
    assign data       = rxready ? mem_q[rd_ptr_q[AW-1:0]] : 8'd0;
    assign done       = push && !p_reset;
    assign overrun    = overrun_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - table-driven bench for uart_rx_fifo (8N1 and 8E1 instances)
module tb_uart_rx_fifo;

    localparam int CPB = 4;

    logic       m_clock = 1'b0;
    logic       p_reset;
    logic       rxd_n, port_read_n, err_clr_n;
    logic       rxd_e, port_read_e, err_clr_e;
    logic [7:0] data_n, data_e;
    logic       rxready_n, rxready_e, done_n, done_e;
    logic [2:0] count_n, count_e;
    logic       overrun_n, overrun_e, perr_n, perr_e, ferr_n, ferr_e;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt_n = 0;
    int done_cnt_e = 0;

    always #5 m_clock = ~m_clock;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
        .m_clock(m_clock), .p_reset(p_reset), .rxd(rxd_n), .port_read(port_read_n),
        .err_clr(err_clr_n), .data(data_n), .rxready(rxready_n), .done(done_n),
        .count(count_n), .overrun(overrun_n), .parity_err(perr_n), .frame_err(ferr_n));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .m_clock(m_clock), .p_reset(p_reset), .rxd(rxd_e), .port_read(port_read_e),
        .err_clr(err_clr_e), .data(data_e), .rxready(rxready_e), .done(done_e),
        .count(count_e), .overrun(overrun_e), .parity_err(perr_e), .frame_err(ferr_e));

    always @(negedge m_clock) begin
        if (done_n) done_cnt_n++;
        if (done_e) done_cnt_e++;
    end

    typedef struct {
        bit         use_e;
        logic [7:0] ch;
        logic       par;
        logic       stop;
        bit         exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rxd(input bit sel, input logic v);
        if (sel) rxd_e = v; else rxd_n = v;
    endtask

    function automatic logic [31:0] o_count(input bit sel);
        return sel ? 32'(count_e) : 32'(count_n);
    endfunction
    function automatic logic [31:0] o_data(input bit sel);
        return sel ? 32'(data_e) : 32'(data_n);
    endfunction
    function automatic logic [31:0] o_rdy(input bit sel);
        return sel ? 32'(rxready_e) : 32'(rxready_n);
    endfunction
    function automatic logic [31:0] o_done(input bit sel);
        return sel ? 32'(done_e) : 32'(done_n);
    endfunction
    function automatic logic [31:0] o_perr(input bit sel);
        return sel ? 32'(perr_e) : 32'(perr_n);
    endfunction
    function automatic logic [31:0] o_ferr(input bit sel);
        return sel ? 32'(ferr_e) : 32'(ferr_n);
    endfunction
    function automatic int o_dcnt(input bit sel);
        return sel ? done_cnt_e : done_cnt_n;
    endfunction

    // Returns on the falling edge inside the cycle that samples the stop bit.
    task automatic send(input bit sel, input logic [7:0] ch, input logic par, input logic stop);
        set_rxd(sel, 1'b0);
        repeat (CPB) @(negedge m_clock);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, ch[i]);
            repeat (CPB) @(negedge m_clock);
        end
        if (sel) begin
            set_rxd(sel, par);
            repeat (CPB) @(negedge m_clock);
        end
        set_rxd(sel, stop);
        repeat (CPB) @(negedge m_clock);
        set_rxd(sel, 1'b1);
    endtask

    task automatic pop(input bit sel);
        if (sel) port_read_e = 1'b1; else port_read_n = 1'b1;
        @(negedge m_clock);
        port_read_e = 1'b0;
        port_read_n = 1'b0;
    endtask

    task automatic clr(input bit sel);
        if (sel) err_clr_e = 1'b1; else err_clr_n = 1'b1;
        @(negedge m_clock);
        err_clr_e = 1'b0;
        err_clr_n = 1'b0;
    endtask

    initial begin
        int d0;
        vecs[0]  = '{0, 8'h41, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[1]  = '{0, 8'hA5, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[2]  = '{0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[3]  = '{0, 8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[4]  = '{0, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[5]  = '{1, 8'h03, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[6]  = '{1, 8'h03, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[7]  = '{1, 8'h07, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[8]  = '{1, 8'h07, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[9]  = '{1, 8'h81, 1'b1, 1'b0, 0, 1'b1, 1'b1};
        vecs[10] = '{1, 8'h80, 1'b1, 1'b1, 1, 1'b0, 1'b0};

        p_reset = 1'b1;
        rxd_n = 1'b1; rxd_e = 1'b1;
        port_read_n = 1'b0; port_read_e = 1'b0;
        err_clr_n = 1'b0; err_clr_e = 1'b0;
        repeat (4) @(negedge m_clock);
        chk("rst_count",   32'(count_n), 0);
        chk("rst_rxready", 32'(rxready_n), 0);
        chk("rst_done",    32'(done_n), 0);
        chk("rst_data",    32'(data_n), 0);
        chk("rst_flags",   {29'd0, overrun_n, perr_n, ferr_n}, 0);
        chk("rst_flags_e", {29'd0, overrun_e, perr_e, ferr_e}, 0);
        p_reset = 1'b0;
        repeat (4) @(negedge m_clock);

        foreach (vecs[v]) begin
            d0 = o_dcnt(vecs[v].use_e);
            send(vecs[v].use_e, vecs[v].ch, vecs[v].par, vecs[v].stop);
            chk($sformatf("v%0d_done_now", v), o_done(vecs[v].use_e), 32'(vecs[v].exp_push));
            repeat (3) @(negedge m_clock);
            chk($sformatf("v%0d_done_pulses", v), 32'(o_dcnt(vecs[v].use_e) - d0), 32'(vecs[v].exp_push));
            chk($sformatf("v%0d_count", v), o_count(vecs[v].use_e), 32'(vecs[v].exp_push));
            chk($sformatf("v%0d_rxready", v), o_rdy(vecs[v].use_e), 32'(vecs[v].exp_push));
            if (vecs[v].exp_push)
                chk($sformatf("v%0d_data", v), o_data(vecs[v].use_e), 32'(vecs[v].ch));
            chk($sformatf("v%0d_perr", v), o_perr(vecs[v].use_e), 32'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v), o_ferr(vecs[v].use_e), 32'(vecs[v].exp_ferr));
            if (vecs[v].exp_push) pop(vecs[v].use_e);
            clr(vecs[v].use_e);
            @(negedge m_clock);
            chk($sformatf("v%0d_after_clean", v),
                {o_count(vecs[v].use_e)[29:0], o_perr(vecs[v].use_e)[0], o_ferr(vecs[v].use_e)[0]}, 0);
        end

        // Overrun: five characters, no reads.
        for (int k = 0; k < 5; k++) send(0, 8'(8'h10 + k), 1'b0, 1'b1);
        chk("ovr_done_on_drop", 32'(done_n), 0);
        repeat (3) @(negedge m_clock);
        chk("ovr_count", 32'(count_n), 4);
        chk("ovr_flag", 32'(overrun_n), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovr_pop%0d", k), 32'(data_n), 32'(8'h10 + k));
            pop(0);
        end
        chk("ovr_empty", 32'(count_n), 0);
        clr(0);
        chk("ovr_clr", 32'(overrun_n), 0);

        // Full FIFO, pop in the push cycle of the fifth character.
        for (int k = 0; k < 4; k++) send(0, 8'(8'h20 + k), 1'b0, 1'b1);
        send(0, 8'h24, 1'b0, 1'b1);
        chk("fullpop_head", 32'(data_n), 32'h20);
        port_read_n = 1'b1;
        #1;
        chk("fullpop_done", 32'(done_n), 1);
        @(negedge m_clock);
        port_read_n = 1'b0;
        repeat (2) @(negedge m_clock);
        chk("fullpop_count", 32'(count_n), 4);
        chk("fullpop_ovr", 32'(overrun_n), 0);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("fullpop_order%0d", k), 32'(data_n), 32'(8'h20 + k));
            pop(0);
        end

        // Break: rxd held low well past a character.
        d0 = done_cnt_n;
        rxd_n = 1'b0;
        repeat (48) @(negedge m_clock);
        chk("break_ferr", 32'(ferr_n), 1);
        chk("break_count", 32'(count_n), 0);
        rxd_n = 1'b1;
        repeat (8) @(negedge m_clock);
        chk("break_no_done", 32'(done_cnt_n - d0), 0);
        clr(0);
        send(0, 8'h5A, 1'b0, 1'b1);
        repeat (3) @(negedge m_clock);
        chk("break_recover", {22'd0, count_n, data_n}, {22'd0, 3'd1, 8'h5A});
        pop(0);

        // Two-cycle glitch.
        d0 = done_cnt_n;
        rxd_n = 1'b0;
        repeat (2) @(negedge m_clock);
        rxd_n = 1'b1;
        repeat (50) @(negedge m_clock);
        chk("glitch_count", 32'(count_n), 0);
        chk("glitch_done", 32'(done_cnt_n - d0), 0);
        chk("glitch_flags", {29'd0, overrun_n, perr_n, ferr_n}, 0);

        // Set wins over a same-cycle clear.
        send(1, 8'h03, 1'b1, 1'b1);
        err_clr_e = 1'b1;
        @(negedge m_clock);
        err_clr_e = 1'b0;
        @(negedge m_clock);
        chk("setwins_perr", 32'(perr_e), 1);
        clr(1);
        chk("setwins_cleared", 32'(perr_e), 0);

        // Reset mid-character.
        d0 = done_cnt_n;
        rxd_n = 1'b0;
        repeat (12) @(negedge m_clock);
        p_reset = 1'b1;
        repeat (2) @(negedge m_clock);
        rxd_n = 1'b1;
        repeat (2) @(negedge m_clock);
        p_reset = 1'b0;
        repeat (50) @(negedge m_clock);
        chk("midrst_count", 32'(count_n), 0);
        chk("midrst_done", 32'(done_cnt_n - d0), 0);
        chk("midrst_flags", {29'd0, overrun_n, perr_n, ferr_n}, 0);
        send(0, 8'h66, 1'b0, 1'b1);
        repeat (3) @(negedge m_clock);
        chk("midrst_recover", {22'd0, count_n, data_n}, {22'd0, 3'd1, 8'h66});
        pop(0);

        // Read while empty is ignored.
        pop(0);
        chk("emptyread_count", 32'(count_n), 0);
        send(0, 8'h77, 1'b0, 1'b1);
        repeat (3) @(negedge m_clock);
        chk("emptyread_next", {22'd0, count_n, data_n}, {22'd0, 3'd1, 8'h77});

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: m_clock cycles per serial bit (legal range 4..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per character (legal range 5..8).
REQ-003 SHALL have parameter PARITY, default 0: parity mode, where 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries (power of 2, 2..256); AW = log2(FIFO_DEPTH).
REQ-006 SHALL have port m_clock, input, 1 bit: the single clock, all logic on its rising edge.
REQ-007 SHALL have port p_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rxd, input, 1 bit: serial line, idle high, asynchronous to m_clock.
REQ-009 SHALL have port port_read, input, 1 bit: pop the FIFO head this cycle.
REQ-010 SHALL have port err_clr, input, 1 bit: clear the sticky error flags.
REQ-011 SHALL have port data, output, 8 bits: FIFO head, zero-extended above DATA_BITS, valid while rxready=1.
REQ-012 SHALL have port rxready, output, 1 bit: FIFO non-empty.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a good character is pushed.
REQ-014 SHALL have port count, output, AW+1 bits: FIFO occupancy.
REQ-015 SHALL have port overrun, output, 1 bit: sticky, set when a character is dropped because the FIFO is full.
REQ-016 SHALL have port parity_err, output, 1 bit: sticky parity error.
REQ-017 SHALL have port frame_err, output, 1 bit: sticky framing error.

Function
REQ-018 rxd SHALL pass through a 2-flop synchroniser before use; all latencies below are counted from the synchronised signal.
REQ-019 The receive FSM SHALL have states IDLE, START, DATA, PAR, STOP and WAITHI.
REQ-020 IDLE -> START SHALL occur on the synchronised high-to-low transition; the bit counter loads CLKS_PER_BIT/2.
REQ-021 At START mid-bit, rxd=1 SHALL be treated as a glitch (return to IDLE, nothing pushed, no error); rxd=0 SHALL go to DATA.
REQ-022 DATA SHALL sample one bit every CLKS_PER_BIT cycles at mid-bit, LSB first, DATA_BITS samples in total.
REQ-023 After DATA the FSM SHALL go to PAR if PARITY != 0, else to STOP.
REQ-024 PAR SHALL sample one bit; a mismatch (XOR of data and parity bit, expected 0 for even, 1 for odd) SHALL mark the character bad-parity.
REQ-025 STOP SHALL sample STOP_BITS bits; any 0 SHALL mark the character bad-frame, and the FSM then goes to WAITHI, otherwise to IDLE.
REQ-026 WAITHI SHALL stay until synchronised rxd=1 (break condition), then go to IDLE.
REQ-027 A good character (no parity or frame error) SHALL be pushed in the cycle its last stop bit is sampled, with done=1 in that same cycle.
REQ-028 A bad character SHALL NOT be pushed; the corresponding sticky flag is set instead; parity and frame errors may both set.
REQ-029 The FIFO SHALL be first-word-fall-through: data = head combinationally; rxready and count update the cycle after a push.
REQ-030 port_read while empty SHALL be ignored, with no pointer change.
REQ-031 A push while full and without a same-cycle pop SHALL drop the character and set overrun, with done=0.
REQ-032 A simultaneous push and pop SHALL both occur, count unchanged, including when full (no overrun).
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be derived from AW+1-bit pointers.
REQ-034 err_clr SHALL clear all three sticky flags; a same-cycle set event SHALL win over the clear.

Reset
REQ-035 p_reset=1 SHALL force state IDLE, pointers 0, count=0, rxready=0, done=0, overrun=0, parity_err=0, frame_err=0, data=0, and the synchroniser flops to 1.
REQ-036 Reset asserted mid-character SHALL abandon that character with no push; after release, reception resumes only on a fresh falling edge.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
REQ-037 Send 0x41 8N1 -> single done pulse, rxready=1, data=0x41, count=1; port_read -> count=0.
REQ-038 PARITY=1: send 0x03 with parity bit 1 -> no push, parity_err=1; err_clr -> 0; send 0x03 with parity 0 -> data=0x03.
REQ-039 Send 5 characters 0x10..0x14 with no reads -> count=4, overrun=1, pops yield 0x10..0x13.
REQ-040 Hold rxd low 40 cycles -> frame_err=1, no push, no new start until rxd returns high.
REQ-041 2-cycle low glitch on rxd -> no push, no error flags.
REQ-042 Full FIFO with port_read pulsed in the push cycle of a 5th character -> count stays 4, overrun=0, order preserved.
